// File: rtl/mem_arbiter.sv
// Two-port (instruction read / data read-write) arbiter in front of a single-cycle
// memory. Round-robin on ties, one transaction every two cycles.
module mem_arbiter #(
    parameter int unsigned MEM_WORDS  = 512,
    parameter int unsigned DATA_FIRST = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic        i_req_i,
    input  logic [31:0] i_addr_i,
    output logic [31:0] i_data_o,
    output logic        i_ack_o,

    input  logic        d_req_i,
    input  logic        d_wen_i,
    input  logic [3:0]  d_stb_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_data_i,
    output logic [31:0] d_data_o,
    output logic        d_ack_o,
    output logic        d_err_o,

    output logic        mem_wen_o,
    output logic [3:0]  mem_stb_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_data_o,
    input  logic [31:0] mem_data_i
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   last_i_q;
    logic   grant_i, grant_d;
    logic   i_oor, d_oor;

    function automatic logic out_of_range(input logic [31:0] addr);
        return addr[31:2] >= 30'(MEM_WORDS);
    endfunction

    assign i_oor = out_of_range(i_addr_i);
    assign d_oor = out_of_range(d_addr_i);

    always_comb begin
        state_d    = state_q;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        mem_wen_o  = 1'b0;
        mem_stb_o  = 4'b0000;
        mem_addr_o = 32'h0;
        mem_data_o = 32'h0;
        case (state_q)
            IDLE: begin
                if (!rst_i && (i_req_i || d_req_i)) begin
                    state_d = RESP;
                    // last_i_q set means the instruction port was served last.
                    if (d_req_i && (!i_req_i || last_i_q)) begin
                        grant_d    = 1'b1;
                        mem_addr_o = d_addr_i;
                        mem_data_o = d_data_i;
                        if (!(d_wen_i && d_oor)) begin
                            mem_wen_o = d_wen_i;
                            mem_stb_o = d_stb_i;
                        end
                    end else begin
                        grant_i    = 1'b1;
                        mem_addr_o = i_addr_i;
                    end
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            last_i_q <= (DATA_FIRST != 0);
            i_ack_o  <= 1'b0;
            d_ack_o  <= 1'b0;
            d_err_o  <= 1'b0;
            i_data_o <= 32'h0;
            d_data_o <= 32'h0;
        end else begin
            state_q <= state_d;
            i_ack_o <= grant_i;
            d_ack_o <= grant_d;
            d_err_o <= grant_d & d_oor;
            if (grant_i) begin
                last_i_q <= 1'b1;
                i_data_o <= i_oor ? 32'h0 : mem_data_i;
            end
            if (grant_d) begin
                last_i_q <= 1'b0;
                if (!d_wen_i)
                    d_data_o <= d_oor ? 32'h0 : mem_data_i;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transactions plus
// hand-written contention and reset sequences against a behavioural memory.
module tb_mem_arbiter;

    logic        clk;
    logic        rst_i;
    logic        i_req_i;
    logic [31:0] i_addr_i;
    logic [31:0] i_data_o;
    logic        i_ack_o;
    logic        d_req_i;
    logic        d_wen_i;
    logic [3:0]  d_stb_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_data_i;
    logic [31:0] d_data_o;
    logic        d_ack_o;
    logic        d_err_o;
    logic        mem_wen_o;
    logic [3:0]  mem_stb_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] mem_data_i;

    logic        mem_init;
    logic [31:0] mem [0:511];

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.MEM_WORDS(512), .DATA_FIRST(1)) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .i_req_i    (i_req_i),
        .i_addr_i   (i_addr_i),
        .i_data_o   (i_data_o),
        .i_ack_o    (i_ack_o),
        .d_req_i    (d_req_i),
        .d_wen_i    (d_wen_i),
        .d_stb_i    (d_stb_i),
        .d_addr_i   (d_addr_i),
        .d_data_i   (d_data_i),
        .d_data_o   (d_data_o),
        .d_ack_o    (d_ack_o),
        .d_err_o    (d_err_o),
        .mem_wen_o  (mem_wen_o),
        .mem_stb_o  (mem_stb_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_data_i (mem_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: async read, byte-strobed synchronous write.
    assign mem_data_i = (mem_addr_o[31:11] == 21'h0) ? mem[mem_addr_o[10:2]] : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int k = 0; k < 512; k++) mem[k] <= 32'hA500_0000 | 32'(k);
            mem[3] <= 32'hDEAD_BEEF;
        end else if (mem_wen_o) begin
            for (int b = 0; b < 4; b++)
                if (mem_stb_o[b]) mem[mem_addr_o[10:2]][8*b +: 8] <= mem_data_o[8*b +: 8];
        end
    end

    typedef struct {
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_wen;
        logic [3:0]  d_stb;
        logic [31:0] d_addr;
        logic [31:0] d_data;
        logic        x_wen;
        logic [3:0]  x_stb;
        logic        x_i_ack;
        logic        x_d_ack;
        logic        x_d_err;
        logic [31:0] x_i_data;
        logic [31:0] x_d_data;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic do_txn(input vec_t v, input string tag);
        @(negedge clk);
        i_req_i  = v.i_req;
        i_addr_i = v.i_addr;
        d_req_i  = v.d_req;
        d_wen_i  = v.d_wen;
        d_stb_i  = v.d_stb;
        d_addr_i = v.d_addr;
        d_data_i = v.d_data;
        #1;
        chk({tag, "_mem_wen"}, 32'(mem_wen_o), 32'(v.x_wen));
        chk({tag, "_mem_stb"}, 32'(mem_stb_o), 32'(v.x_stb));
        @(posedge clk);
        #1;
        chk({tag, "_i_ack"},  32'(i_ack_o), 32'(v.x_i_ack));
        chk({tag, "_d_ack"},  32'(d_ack_o), 32'(v.x_d_ack));
        chk({tag, "_d_err"},  32'(d_err_o), 32'(v.x_d_err));
        chk({tag, "_i_data"}, i_data_o, v.x_i_data);
        chk({tag, "_d_data"}, d_data_o, v.x_d_data);
        i_req_i = 1'b0;
        d_req_i = 1'b0;
        d_wen_i = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_i_ack_clr"}, 32'(i_ack_o), 32'h0);
        chk({tag, "_d_ack_clr"}, 32'(d_ack_o), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rb;
        //          i_req i_addr        d_req d_wen d_stb d_addr        d_data         wen   stb    iack  dack  derr  i_data         d_data
        vecs[0]  = '{1'b1, 32'h0000_000C, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,         1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h0};
        vecs[1]  = '{1'b0, 32'h0,        1'b1, 1'b1, 4'h2, 32'h0000_0010, 32'h0000_AB00, 1'b1, 4'h2, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0};
        vecs[2]  = '{1'b0, 32'h0,        1'b1, 1'b0, 4'h0, 32'h0000_0010, 32'h0,         1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'hA500_AB04};
        vecs[3]  = '{1'b0, 32'h0,        1'b1, 1'b0, 4'h0, 32'h0000_0800, 32'h0,         1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0};
        vecs[4]  = '{1'b0, 32'h0,        1'b1, 1'b1, 4'hF, 32'h0000_0800, 32'h1234_5678, 1'b0, 4'h0, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h0};
        vecs[5]  = '{1'b1, 32'h0000_0800, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,         1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0};
        vecs[6]  = '{1'b1, 32'h0000_0010, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,         1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 32'hA500_AB04, 32'h0};
        vecs[7]  = '{1'b1, 32'h0000_0014, 1'b1, 1'b0, 4'h0, 32'h0000_000C, 32'h0,         1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 32'hA500_AB04, 32'hDEAD_BEEF};
        vecs[8]  = '{1'b1, 32'h0000_0014, 1'b1, 1'b1, 4'hF, 32'h0000_0018, 32'hCAFE_F00D, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 32'hA500_0005, 32'hDEAD_BEEF};
        vecs[9]  = '{1'b0, 32'h0,        1'b1, 1'b1, 4'hC, 32'h0000_0018, 32'h1122_3344, 1'b1, 4'hC, 1'b0, 1'b1, 1'b0, 32'hA500_0005, 32'hDEAD_BEEF};
        vecs[10] = '{1'b0, 32'h0,        1'b1, 1'b0, 4'h0, 32'h0000_0018, 32'h0,         1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 32'hA500_0005, 32'h1122_0006};
        vecs[11] = '{1'b0, 32'h0,        1'b1, 1'b0, 4'h0, 32'h0000_07FC, 32'h0,         1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 32'hA500_0005, 32'hA500_01FF};
        vecs[12] = '{1'b1, 32'h0000_000F, 1'b0, 1'b0, 4'h0, 32'h0,        32'h0,         1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'hA500_01FF};

        rst_i    = 1'b1;
        mem_init = 1'b1;
        i_req_i  = 1'b0;
        i_addr_i = 32'h0;
        d_req_i  = 1'b0;
        d_wen_i  = 1'b0;
        d_stb_i  = 4'h0;
        d_addr_i = 32'h0;
        d_data_i = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_i_ack",  32'(i_ack_o), 32'h0);
        chk("rst_d_ack",  32'(d_ack_o), 32'h0);
        chk("rst_d_err",  32'(d_err_o), 32'h0);
        chk("rst_i_data", i_data_o, 32'h0);
        chk("rst_d_data", d_data_o, 32'h0);
        chk("rst_mem_wen", 32'(mem_wen_o), 32'h0);
        @(negedge clk);
        rst_i    = 1'b0;
        mem_init = 1'b0;

        for (int i = 0; i < 13; i++) do_txn(vecs[i], $sformatf("v%0d", i));

        // Both ports held from reset: data wins first, then strict alternation.
        @(negedge clk);
        rst_i    = 1'b1;
        i_req_i  = 1'b1;
        i_addr_i = 32'h0000_0014;
        d_req_i  = 1'b1;
        d_wen_i  = 1'b0;
        d_stb_i  = 4'h0;
        d_addr_i = 32'h0000_000C;
        #1;
        chk("cont_rst_mem_addr", mem_addr_o, 32'h0);
        @(posedge clk);
        #1;
        chk("cont_rst_d_data", d_data_o, 32'h0);
        chk("cont_rst_i_data", i_data_o, 32'h0);
        @(negedge clk);
        rst_i = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("cont%0d_d_ack", c), 32'(d_ack_o), 32'((c % 4) == 0));
            chk($sformatf("cont%0d_i_ack", c), 32'(i_ack_o), 32'((c % 4) == 2));
            if (c == 0) chk("cont0_d_data", d_data_o, 32'hDEAD_BEEF);
            if (c == 2) chk("cont2_i_data", i_data_o, 32'hA500_0005);
        end
        i_req_i = 1'b0;
        d_req_i = 1'b0;
        @(posedge clk);

        // Reset during the ack cycle of a write, then reset with a write pending.
        @(negedge clk);
        d_req_i  = 1'b1;
        d_wen_i  = 1'b1;
        d_stb_i  = 4'hF;
        d_addr_i = 32'h0000_0020;
        d_data_i = 32'h55AA_55AA;
        #1;
        chk("rr_wen", 32'(mem_wen_o), 32'h1);
        @(posedge clk);
        #1;
        chk("rr_d_ack", 32'(d_ack_o), 32'h1);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        chk("rr_d_ack_abort", 32'(d_ack_o), 32'h0);
        chk("rr_d_err",       32'(d_err_o), 32'h0);
        chk("rr_d_data",      d_data_o, 32'h0);
        chk("rr_i_data",      i_data_o, 32'h0);
        d_addr_i = 32'h0000_001C;
        d_data_i = 32'hFFFF_FFFF;
        #1;
        chk("rr_pend_wen",  32'(mem_wen_o), 32'h0);
        chk("rr_pend_stb",  32'(mem_stb_o), 32'h0);
        chk("rr_pend_addr", mem_addr_o, 32'h0);
        chk("rr_pend_data", mem_data_o, 32'h0);
        @(posedge clk);
        #1;
        chk("rr_pend_d_ack", 32'(d_ack_o), 32'h0);
        @(negedge clk);
        rst_i   = 1'b0;
        d_req_i = 1'b0;
        d_wen_i = 1'b0;

        rb = '{1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0000_0020, 32'h0,
               1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h55AA_55AA};
        do_txn(rb, "rb_committed");
        rb = '{1'b0, 32'h0, 1'b1, 1'b0, 4'h0, 32'h0000_001C, 32'h0,
               1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'hA500_0007};
        do_txn(rb, "rb_blocked");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    always @(negedge clk) begin
        if (i_ack_o && d_ack_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL dual_ack: got i_ack=%b d_ack=%b, expected at most one", i_ack_o, d_ack_o);
        end
        if (!d_ack_o && d_err_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL err_without_ack: got d_err=%b, expected 0", d_err_o);
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MEM_WORDS, default 512, meaning: number of 32-bit words in the attached memory; word index addr[31:2] >= MEM_WORDS is out of range.
REQ-002 Parameter DATA_FIRST, default 1, meaning: reset value of the round-robin pointer; 1 gives the data port the first tie.
REQ-003 clk_i  in  1  single clock; all state updates on posedge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 i_req_i  in  1  instruction-port read request, held until i_ack_o.
REQ-006 i_addr_i  in  32  instruction byte address; bits [1:0] ignored.
REQ-007 i_data_o  out  32  instruction read data, registered.
REQ-008 i_ack_o  out  1  one-cycle instruction completion pulse.
REQ-009 d_req_i  in  1  data-port request, held until d_ack_o.
REQ-010 d_wen_i  in  1  data-port write enable (0 = read).
REQ-011 d_stb_i  in  4  data-port byte strobes for writes.
REQ-012 d_addr_i  in  32  data byte address; bits [1:0] ignored.
REQ-013 d_data_i  in  32  data-port write data.
REQ-014 d_data_o  out  32  data-port read data, registered.
REQ-015 d_ack_o  out  1  one-cycle data completion pulse.
REQ-016 d_err_o  out  1  asserted with d_ack_o when the access was out of range.
REQ-017 mem_wen_o  out  1  memory write enable.
REQ-018 mem_stb_o  out  4  memory byte strobes.
REQ-019 mem_addr_o  out  32  memory byte address.
REQ-020 mem_data_o  out  32  memory write data.
REQ-021 mem_data_i  in  32  memory asynchronous read data.

Function
REQ-022 FSM states: IDLE, RESP; IDLE->RESP when any request is present, RESP->IDLE unconditionally; one transaction per 2 cycles max.
REQ-023 In IDLE with requests present, winner selected combinationally: only one requester -> it wins; both -> port opposite to round-robin pointer's last-served port wins.
REQ-024 In IDLE, mem_addr_o = winner address; winner data port drives mem_wen_o = d_wen_i, mem_stb_o = d_stb_i, mem_data_o = d_data_i; instruction winner drives mem_wen_o = 0, mem_stb_o = 0.
REQ-025 Out-of-range data write: mem_wen_o forced 0, mem_stb_o forced 0.
REQ-026 With no request, in RESP, or while rst_i = 1: mem_wen_o = 0, mem_stb_o = 0; mem_addr_o and mem_data_o = 0.
REQ-027 At the IDLE->RESP edge: winner's ack registered to 1 for the RESP cycle; read winner captures mem_data_i into its data_o; pointer updated to winner.
REQ-028 Out-of-range access: ack still given; read data_o loaded with 0; d_err_o = 1 in same cycle as d_ack_o (instruction port out-of-range returns 0, no error flag).
REQ-029 Write completion leaves d_data_o unchanged; each data_o holds value until that port's next read completion.
REQ-030 i_ack_o and d_ack_o never both 1; each is high exactly one cycle per transaction; d_err_o = 0 whenever d_ack_o = 0.
REQ-031 Requests sampled only in IDLE; a request still high during its ack (RESP) cycle is not re-served until the following IDLE cycle.
REQ-032 Loser of a tie remains pending and is served in the next IDLE cycle if still requested (no starvation: max wait 2 cycles).

Reset
REQ-033 rst_i = 1 at posedge: state = IDLE, pointer = DATA_FIRST, i_ack_o = d_ack_o = d_err_o = 0, i_data_o = d_data_o = 0.
REQ-034 Reset asserted in RESP aborts the ack (ack 0 next cycle); a write already committed at the prior edge is not undone.
REQ-035 Reset asserted in IDLE with pending write: no memory write occurs (mem_wen_o gated by rst_i).

Verification
REQ-036 Single read: mem word 3 = 0xDEADBEEF, i_req_i=1, i_addr_i=0x0C -> cycle+1 i_ack_o=1, i_data_o=0xDEADBEEF, mem_wen_o never 1.
REQ-037 Byte write: d_req_i=1, d_wen_i=1, d_stb_i=0b0010, d_addr_i=0x10, d_data_i=0x0000AB00 -> mem_wen_o=1 for one cycle, mem_stb_o=0b0010, d_ack_o=1 next cycle, d_err_o=0.
REQ-038 Contention: both requests held continuously from reset with DATA_FIRST=1 -> acks alternate d,i,d,i on every second cycle; neither port skipped.
REQ-039 Out of range: d read at 0x800 (word 512) -> d_ack_o=1, d_err_o=1, d_data_o=0; write at 0x800 -> mem_wen_o stays 0, d_err_o=1.
REQ-040 Reset mid-transaction: rst_i=1 during RESP cycle -> d_ack_o=0 next cycle, state IDLE, outputs at reset values; rst_i=1 with pending write in IDLE -> mem_wen_o=0.
